// File: rtl/change_dispenser.sv
// -----------------------------------------------------------------------------
// change_dispenser
//   Pays out a change amount one coin at a time, greedy largest-first
//   (20, 10, 5). A denomination is used only while its inventory is non-zero.
//   Each coin is handed to the hopper over a valid/ack handshake. The block
//   ends with either a done pulse (remainder reached 0) or a short_change
//   pulse (remainder cannot be paid from what is left in inventory).
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   start         one-cycle request to pay out change_amt (honoured in IDLE)
//   change_amt    amount to pay, sampled with start
//   coin_ack      hopper has taken the presented coin
//   refill        reload all inventories (honoured in IDLE without start)
//   busy          high whenever the machine is not in IDLE
//   coin_valid    a coin is being presented
//   coin_5/10/20  one-hot coin select, qualified by coin_valid
//   done          one-cycle pulse, change fully paid
//   short_change  one-cycle pulse, remainder could not be paid
//   remaining     current undispensed amount
//   cnt_5/10/20   per-denomination inventory
// -----------------------------------------------------------------------------
module change_dispenser #(
    parameter int AMT_W   = 6,
    parameter int CNT_W   = 4,
    parameter int INIT_5  = 8,
    parameter int INIT_10 = 8,
    parameter int INIT_20 = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             coin_ack,
    input  logic             refill,
    output logic             busy,
    output logic             coin_valid,
    output logic             coin_5,
    output logic             coin_10,
    output logic             coin_20,
    output logic             done,
    output logic             short_change,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] cnt_5,
    output logic [CNT_W-1:0] cnt_10,
    output logic [CNT_W-1:0] cnt_20
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        DISPENSE = 3'd2,
        DONE     = 3'd3,
        ERROR    = 3'd4
    } state_t;

    // One-hot coin select, bit order {20, 10, 5}.
    localparam logic [2:0] SEL_NONE = 3'b000;
    localparam logic [2:0] SEL_5    = 3'b001;
    localparam logic [2:0] SEL_10   = 3'b010;
    localparam logic [2:0] SEL_20   = 3'b100;

    localparam logic [AMT_W-1:0] VAL_5  = AMT_W'(5);
    localparam logic [AMT_W-1:0] VAL_10 = AMT_W'(10);
    localparam logic [AMT_W-1:0] VAL_20 = AMT_W'(20);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [AMT_W-1:0] remaining_reg, remaining_next;
    logic [CNT_W-1:0] cnt_5_reg, cnt_5_next;
    logic [CNT_W-1:0] cnt_10_reg, cnt_10_next;
    logic [CNT_W-1:0] cnt_20_reg, cnt_20_next;
    logic [2:0]       coin_sel_reg, coin_sel_next;

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            cnt_5_reg     <= CNT_W'(INIT_5);
            cnt_10_reg    <= CNT_W'(INIT_10);
            cnt_20_reg    <= CNT_W'(INIT_20);
            coin_sel_reg  <= SEL_NONE;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            cnt_5_reg     <= cnt_5_next;
            cnt_10_reg    <= cnt_10_next;
            cnt_20_reg    <= cnt_20_next;
            coin_sel_reg  <= coin_sel_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        cnt_5_next     = cnt_5_reg;
        cnt_10_next    = cnt_10_reg;
        cnt_20_next    = cnt_20_reg;
        coin_sel_next  = coin_sel_reg;

        case (state_reg)
            IDLE: begin
                // start has priority; a simultaneous refill is simply lost.
                if (start) begin
                    remaining_next = change_amt;
                    state_next     = SELECT;
                end else if (refill) begin
                    cnt_5_next  = CNT_W'(INIT_5);
                    cnt_10_next = CNT_W'(INIT_10);
                    cnt_20_next = CNT_W'(INIT_20);
                end
            end

            SELECT: begin
                // Selecting only when value <= remaining and count > 0 keeps
                // both the subtraction and the decrement in DISPENSE safe.
                if (remaining_reg == '0) begin
                    state_next = DONE;
                end else if (remaining_reg >= VAL_20 && cnt_20_reg != '0) begin
                    coin_sel_next = SEL_20;
                    state_next    = DISPENSE;
                end else if (remaining_reg >= VAL_10 && cnt_10_reg != '0) begin
                    coin_sel_next = SEL_10;
                    state_next    = DISPENSE;
                end else if (remaining_reg >= VAL_5 && cnt_5_reg != '0) begin
                    coin_sel_next = SEL_5;
                    state_next    = DISPENSE;
                end else begin
                    // Residue that is not a multiple of 5, or inventory exhausted.
                    state_next = ERROR;
                end
            end

            DISPENSE: begin
                if (coin_ack) begin
                    state_next = SELECT;
                    case (coin_sel_reg)
                        SEL_20: begin
                            remaining_next = remaining_reg - VAL_20;
                            cnt_20_next    = cnt_20_reg - CNT_ONE;
                        end
                        SEL_10: begin
                            remaining_next = remaining_reg - VAL_10;
                            cnt_10_next    = cnt_10_reg - CNT_ONE;
                        end
                        SEL_5: begin
                            remaining_next = remaining_reg - VAL_5;
                            cnt_5_next     = cnt_5_reg - CNT_ONE;
                        end
                        default: begin
                            remaining_next = remaining_reg;
                        end
                    endcase
                end
            end

            DONE:    state_next = IDLE;
            ERROR:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Moore output decode
    // -------------------------------------------------------------------------
    assign busy         = (state_reg != IDLE);
    assign coin_valid   = (state_reg == DISPENSE);
    assign coin_5       = coin_valid & coin_sel_reg[0];
    assign coin_10      = coin_valid & coin_sel_reg[1];
    assign coin_20      = coin_valid & coin_sel_reg[2];
    assign done         = (state_reg == DONE);
    assign short_change = (state_reg == ERROR);
    assign remaining    = remaining_reg;
    assign cnt_5        = cnt_5_reg;
    assign cnt_10       = cnt_10_reg;
    assign cnt_20       = cnt_20_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// -----------------------------------------------------------------------------
// tb_change_dispenser
//   Directed bench for change_dispenser. Coins accepted by the hopper are
//   packed 5 bits each into a sequence word and compared against
//   hand-computed sequences.
// -----------------------------------------------------------------------------
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [5:0] change_amt;
    logic       coin_ack;
    logic       refill;
    logic       busy;
    logic       coin_valid;
    logic       coin_5;
    logic       coin_10;
    logic       coin_20;
    logic       done;
    logic       short_change;
    logic [5:0] remaining;
    logic [3:0] cnt_5;
    logic [3:0] cnt_10;
    logic [3:0] cnt_20;

    int tests_run = 0;
    int tests_failed = 0;

    // Per-transaction observations.
    logic [63:0] seq;
    int          ncoins;
    int          done_cyc;
    int          short_cyc;
    int          busy_cnt;
    int          cyc;

    change_dispenser #(
        .AMT_W  (6),
        .CNT_W  (4),
        .INIT_5 (8),
        .INIT_10(8),
        .INIT_20(4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .change_amt  (change_amt),
        .coin_ack    (coin_ack),
        .refill      (refill),
        .busy        (busy),
        .coin_valid  (coin_valid),
        .coin_5      (coin_5),
        .coin_10     (coin_10),
        .coin_20     (coin_20),
        .done        (done),
        .short_change(short_change),
        .remaining   (remaining),
        .cnt_5       (cnt_5),
        .cnt_10      (cnt_10),
        .cnt_20      (cnt_20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: %0d", tag, got);
        end
    endtask

    // Value of the presented coin; 31 flags a non-one-hot select.
    function automatic int coin_val();
        case ({coin_20, coin_10, coin_5})
            3'b100:  return 20;
            3'b010:  return 10;
            3'b001:  return 5;
            default: return 31;
        endcase
    endfunction

    function automatic logic [63:0] push(input logic [63:0] s, input int v);
        return (s << 5) | 64'(v);
    endfunction

    // Follow a running transaction from the current sample point (#1 after a
    // rising edge) until the cycle after done/short_change, bounded.
    task automatic collect();
        bit finished;
        finished = 1'b0;
        while (!finished && cyc <= 80) begin
            if (busy) busy_cnt++;
            if (coin_valid && coin_ack) begin
                seq = push(seq, coin_val());
                ncoins++;
            end
            if (done) done_cyc = cyc;
            if (short_change) short_cyc = cyc;
            if (done || short_change) finished = 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        if (!finished) check("timeout_busy", {63'd0, busy}, 64'd0);
    endtask

    // Issue start (optionally with refill in the same cycle) and collect.
    task automatic pay(input logic [5:0] amt, input logic rf);
        start      = 1'b1;
        change_amt = amt;
        refill     = rf;
        @(posedge clk); #1;
        start     = 1'b0;
        refill    = 1'b0;
        seq       = '0;
        ncoins    = 0;
        done_cyc  = -1;
        short_cyc = -1;
        busy_cnt  = 0;
        cyc       = 1;
        collect();
    endtask

    initial begin
        logic [63:0] exp_seq;

        reset      = 1'b1;
        start      = 1'b0;
        change_amt = '0;
        coin_ack   = 1'b1;
        refill     = 1'b0;
        seq        = '0;
        ncoins     = 0;
        done_cyc   = -1;
        short_cyc  = -1;
        busy_cnt   = 0;
        cyc        = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",       {63'd0, busy}, 64'd0);
        check("rst_coin_valid", {63'd0, coin_valid}, 64'd0);
        check("rst_done",       {63'd0, done}, 64'd0);
        check("rst_short",      {63'd0, short_change}, 64'd0);
        check("rst_remaining",  64'(remaining), 64'd0);
        check("rst_cnt_5",      64'(cnt_5), 64'd8);
        check("rst_cnt_10",     64'(cnt_10), 64'd8);
        check("rst_cnt_20",     64'(cnt_20), 64'd4);
        reset = 1'b0;
        @(posedge clk); #1;

        // 35 -> 20, 10, 5; done at cycle 8.
        pay(6'd35, 1'b0);
        exp_seq = push(push(push(64'd0, 20), 10), 5);
        check("p35_seq",       seq, exp_seq);
        check("p35_done_cyc",  64'(done_cyc), 64'd8);
        check("p35_no_short",  64'(short_cyc), 64'(-1));
        check("p35_remaining", 64'(remaining), 64'd0);
        check("p35_cnt_20",    64'(cnt_20), 64'd3);
        check("p35_cnt_10",    64'(cnt_10), 64'd7);
        check("p35_cnt_5",     64'(cnt_5), 64'd7);

        // 0 -> no coins, done at cycle 2, busy cycles 1-2 only.
        pay(6'd0, 1'b0);
        check("p0_ncoins",   64'(ncoins), 64'd0);
        check("p0_done_cyc", 64'(done_cyc), 64'd2);
        check("p0_busy_cnt", 64'(busy_cnt), 64'd2);
        check("p0_idle",     {63'd0, busy}, 64'd0);

        // Drain 20s: 60 -> 20,20,20 (cnt_20 3 -> 0).
        pay(6'd60, 1'b0);
        exp_seq = push(push(push(64'd0, 20), 20), 20);
        check("p60a_seq",    seq, exp_seq);
        check("p60a_cnt_20", 64'(cnt_20), 64'd0);
        // 60 again with no 20s -> six 10s (cnt_10 7 -> 1).
        pay(6'd60, 1'b0);
        exp_seq = '0;
        for (int i = 0; i < 6; i++) exp_seq = push(exp_seq, 10);
        check("p60b_seq",    seq, exp_seq);
        check("p60b_cnt_10", 64'(cnt_10), 64'd1);
        // 40 with one 10 left -> 10 then six 5s.
        pay(6'd40, 1'b0);
        exp_seq = push(64'd0, 10);
        for (int i = 0; i < 6; i++) exp_seq = push(exp_seq, 5);
        check("p40_seq",      seq, exp_seq);
        check("p40_done",     64'(done_cyc), 64'd16);
        check("p40_cnt_10",   64'(cnt_10), 64'd0);
        check("p40_cnt_5",    64'(cnt_5), 64'd1);

        // Refill in IDLE.
        refill = 1'b1;
        @(posedge clk); #1;
        refill = 1'b0;
        check("refill_cnt_5",  64'(cnt_5), 64'd8);
        check("refill_cnt_10", 64'(cnt_10), 64'd8);
        check("refill_cnt_20", 64'(cnt_20), 64'd4);

        // 23 -> 20 then short_change with remainder 3.
        pay(6'd23, 1'b0);
        check("p23_seq",       seq, push(64'd0, 20));
        check("p23_short_cyc", 64'(short_cyc), 64'd4);
        check("p23_no_done",   64'(done_cyc), 64'(-1));
        check("p23_remaining", 64'(remaining), 64'd3);
        check("p23_cnt_20",    64'(cnt_20), 64'd3);

        // Stall: 15 with coin_ack low for 5 DISPENSE cycles; start pulsed
        // mid-stall must be ignored.
        coin_ack   = 1'b0;
        start      = 1'b1;
        change_amt = 6'd15;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;   // SELECT
        @(posedge clk); #1;   // DISPENSE
        for (int i = 0; i < 5; i++) begin
            start      = 1'b0;
            check("stall_valid",  {63'd0, coin_valid}, 64'd1);
            check("stall_coin",   64'(coin_val()), 64'd10);
            check("stall_cnt_10", 64'(cnt_10), 64'd8);
            if (i == 2) begin
                start      = 1'b1;
                change_amt = 6'd50;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        coin_ack  = 1'b1;
        seq       = '0;
        ncoins    = 0;
        done_cyc  = -1;
        short_cyc = -1;
        busy_cnt  = 0;
        cyc       = 7;
        collect();
        check("stall_seq",       seq, push(push(64'd0, 10), 5));
        check("stall_done_cyc",  64'(done_cyc), 64'd11);
        check("stall_remaining", 64'(remaining), 64'd0);
        check("stall_cnt_10",    64'(cnt_10), 64'd7);
        check("stall_cnt_5",     64'(cnt_5), 64'd7);

        // Reset mid-DISPENSE takes effect without waiting for a clock.
        coin_ack   = 1'b0;
        start      = 1'b1;
        change_amt = 6'd20;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;   // SELECT
        @(posedge clk); #1;   // DISPENSE
        check("pre_rst_valid", {63'd0, coin_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("arst_valid",     {63'd0, coin_valid}, 64'd0);
        check("arst_busy",      {63'd0, busy}, 64'd0);
        check("arst_remaining", 64'(remaining), 64'd0);
        check("arst_cnt_20",    64'(cnt_20), 64'd4);
        check("arst_cnt_10",    64'(cnt_10), 64'd8);
        check("arst_cnt_5",     64'(cnt_5), 64'd8);
        @(posedge clk); #1;
        reset    = 1'b0;
        coin_ack = 1'b1;
        @(posedge clk); #1;

        // Spend one 5, then start+refill together: refill must be dropped.
        pay(6'd5, 1'b0);
        check("p5_cnt_5", 64'(cnt_5), 64'd7);
        pay(6'd10, 1'b1);
        check("sr_seq",      seq, push(64'd0, 10));
        check("sr_done_cyc", 64'(done_cyc), 64'd4);
        check("sr_cnt_5",    64'(cnt_5), 64'd7);
        check("sr_cnt_10",   64'(cnt_10), 64'd7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
